// File: rtl/vga_window_engine.sv
// vga_window_engine
//   Parametrised VGA timing generator with a rectangular window fetch from
//   an external synchronous pixel RAM. Sync, DE and frame_start are delayed
//   so that they line up with the RAM data. Active pixels outside the window
//   show BG_COLOR. Video enable is sampled only at the start of a frame.
//
// Ports
//   clk_i          pixel clock
//   rst_n_i        asynchronous active-low reset
//   en_i           video enable, sampled at h_cnt=0 / v_cnt=0
//   data_i         RAM read data {R,G,B}, valid RD_LAT clocks after addr_o
//   addr_o         RAM read address (window raster order)
//   hsync_o        horizontal sync, asserted level H_POL
//   vsync_o        vertical sync, asserted level V_POL
//   de_o           data enable
//   red_o/green_o/blue_o  pixel colour
//   frame_start_o  one-cycle pulse with the first active pixel of a frame
//
// Latency: counter state at cycle t -> addr_o at t+1 -> data_i at t+1+RD_LAT
//          -> all video outputs at t+2+RD_LAT.

module vga_window_engine #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 56,
    parameter int unsigned H_SYNC   = 120,
    parameter int unsigned H_BP     = 64,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned V_FP     = 37,
    parameter int unsigned V_SYNC   = 6,
    parameter int unsigned V_BP     = 23,
    parameter int unsigned H_POL    = 1,
    parameter int unsigned V_POL    = 1,
    parameter int unsigned WIN_X    = 65,
    parameter int unsigned WIN_Y    = 100,
    parameter int unsigned WIN_W    = 128,
    parameter int unsigned WIN_H    = 128,
    parameter int unsigned ADDR_W   = 14,
    parameter int unsigned RD_LAT   = 1,
    parameter logic [23:0] BG_COLOR = 24'h000000
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              en_i,
    input  logic [23:0]       data_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic              de_o,
    output logic [7:0]        red_o,
    output logic [7:0]        green_o,
    output logic [7:0]        blue_o,
    output logic              frame_start_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
    localparam int unsigned HS_END  = HS_BEG + H_SYNC;
    localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
    localparam int unsigned VS_END  = VS_BEG + V_SYNC;
    localparam int unsigned PD      = RD_LAT + 1;   // stages ahead of the output register
    localparam logic        HP      = (H_POL != 0);
    localparam logic        VP      = (V_POL != 0);

    // pipeline word: {frame_start, in_win, de, vsync, hsync}
    localparam logic [4:0]  PIPE_RST = {1'b0, 1'b0, 1'b0, ~VP, ~HP};

    if (WIN_X + WIN_W > H_ACTIVE) begin : g_err_win_x
        $error("vga_window_engine: window exceeds H_ACTIVE");
    end
    if (WIN_Y + WIN_H > V_ACTIVE) begin : g_err_win_y
        $error("vga_window_engine: window exceeds V_ACTIVE");
    end
    if (64'(WIN_W) * 64'(WIN_H) > (64'd1 << ADDR_W)) begin : g_err_addr
        $error("vga_window_engine: window does not fit ADDR_W");
    end
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_err_lat
        $error("vga_window_engine: RD_LAT must be 1..4");
    end

    logic [HW-1:0]     h_cnt_q, h_cnt_d;
    logic [VW-1:0]     v_cnt_q, v_cnt_d;
    logic [31:0]       h_ext, v_ext;
    logic              h_last, v_last, frame_top;
    logic              en_frame_q, en_frame_d, en_eff;
    logic              raw_hs, raw_vs, raw_de, raw_win, raw_fs;
    logic [ADDR_W-1:0] addr_q, addr_d, next_q, next_d, base;
    logic [4:0]        pipe_q [PD];
    logic [4:0]        tail;
    logic              hsync_q, vsync_q, de_q, fs_q;
    logic [23:0]       rgb_q, rgb_d;

    assign h_ext     = 32'(h_cnt_q);
    assign v_ext     = 32'(v_cnt_q);
    assign h_last    = (h_ext == H_TOTAL - 1);
    assign v_last    = (v_ext == V_TOTAL - 1);
    assign frame_top = (h_cnt_q == '0) && (v_cnt_q == '0);

    always_comb begin
        h_cnt_d = h_last ? '0 : h_cnt_q + HW'(1);
        v_cnt_d = v_cnt_q;
        if (h_last) begin
            v_cnt_d = v_last ? '0 : v_cnt_q + VW'(1);
        end
    end

    // The first pixel of a frame already uses the freshly sampled enable.
    assign en_eff     = frame_top ? en_i : en_frame_q;
    assign en_frame_d = en_eff;

    assign raw_hs  = (h_ext >= HS_BEG && h_ext < HS_END) ? HP : ~HP;
    assign raw_vs  = (v_ext >= VS_BEG && v_ext < VS_END) ? VP : ~VP;
    assign raw_de  = (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE) && en_eff;
    assign raw_win = raw_de
                     && (h_ext >= WIN_X) && (h_ext < WIN_X + WIN_W)
                     && (v_ext >= WIN_Y) && (v_ext < WIN_Y + WIN_H);
    assign raw_fs  = frame_top && en_eff;

    // next_q holds the address the next window pixel will use; addr_q is the
    // address of the most recent window pixel (the one the RAM is reading).
    always_comb begin
        base   = frame_top ? '0 : next_q;
        addr_d = frame_top ? '0 : addr_q;
        next_d = base;
        if (raw_win) begin
            addr_d = base;
            next_d = base + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            en_frame_q <= 1'b0;
            addr_q     <= '0;
            next_q     <= '0;
        end else begin
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            en_frame_q <= en_frame_d;
            addr_q     <= addr_d;
            next_q     <= next_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < PD; i++) begin
                pipe_q[i] <= PIPE_RST;
            end
        end else begin
            pipe_q[0] <= {raw_fs, raw_win, raw_de, raw_vs, raw_hs};
            for (int i = 1; i < PD; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign tail = pipe_q[PD-1];

    always_comb begin
        rgb_d = '0;
        if (tail[3]) begin
            rgb_d = data_i;
        end else if (tail[2]) begin
            rgb_d = BG_COLOR;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hsync_q <= ~HP;
            vsync_q <= ~VP;
            de_q    <= 1'b0;
            fs_q    <= 1'b0;
            rgb_q   <= '0;
        end else begin
            hsync_q <= tail[0];
            vsync_q <= tail[1];
            de_q    <= tail[2];
            fs_q    <= tail[4];
            rgb_q   <= rgb_d;
        end
    end

    assign addr_o        = addr_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign de_o          = de_q;
    assign frame_start_o = fs_q;
    assign red_o         = rgb_q[23:16];
    assign green_o       = rgb_q[15:8];
    assign blue_o        = rgb_q[7:0];

endmodule
